fetch_seq: RTL
==============

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter and address width.
REQ-002 SHALL have parameter HALT_OP, default 8'hFF, opcode that stops sequencing.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port run  input  1  level; start/continue fetching when high.
REQ-006 SHALL have port mem_rd  output  1  memory read request.
REQ-007 SHALL have port mem_addr  output  PC_W  read address, equals pc while mem_rd high.
REQ-008 SHALL have port mem_ready  input  1  read data valid this cycle.
REQ-009 SHALL have port load_upper  output  1  drives the instruction register's high-byte load (opcode).
REQ-010 SHALL have port load_lower  output  1  drives the instruction register's low-byte load (operand).
REQ-011 SHALL have port opcode  input  8  registered opcode returned from the instruction register.
REQ-012 SHALL have port exec_start  output  1  one-cycle pulse; instruction ready to execute.
REQ-013 SHALL have port exec_done  input  1  execute stage finished.
REQ-014 SHALL have port jump_en / jump_addr  input  1 / PC_W  sampled with exec_done; redirect pc.
REQ-015 SHALL have port pc  output  PC_W  current program counter.
REQ-016 SHALL have port halted  output  1  high in HALT (and FAULT if compiled in).

Function
REQ-017 SHALL implement states IDLE, FETCH_HI, FETCH_LO, DECODE, EXEC, HALT (+FAULT, see Configuration).
REQ-018 IDLE: run=1 -> FETCH_HI next cycle; run=0 -> stay.
REQ-019 FETCH_HI: mem_rd=1, mem_addr=pc; load_upper = mem_ready (same cycle, combinational); on mem_ready: pc <= pc+1, -> FETCH_LO; else hold all outputs.
REQ-020 FETCH_LO: same handshake, load_lower = mem_ready; on mem_ready: pc <= pc+1, -> DECODE.
REQ-021 load_upper and load_lower SHALL never be high in the same cycle; neither high outside FETCH_HI/FETCH_LO.
REQ-022 DECODE (one cycle, opcode now registered): opcode==HALT_OP -> HALT; else exec_start=1, -> EXEC.
REQ-023 EXEC: wait for exec_done; on exec_done: jump_en ? pc <= jump_addr : pc unchanged; run ? -> FETCH_HI : -> IDLE.
REQ-024 exec_done outside EXEC SHALL be ignored; exec_start SHALL be exactly one cycle per instruction.
REQ-025 pc SHALL wrap modulo 2^PC_W (e.g. 8'hFF+1 -> 8'h00) with no flag.
REQ-026 run deasserted mid-fetch SHALL NOT abort the fetch; it takes effect only at the EXEC->next decision.
REQ-027 HALT: halted=1, mem_rd=0, exit only by reset.
REQ-028 Minimum instruction latency with mem_ready tied high: FETCH_HI, FETCH_LO, DECODE, EXEC(exec_done same cycle) = 4 cycles.

Reset
REQ-029 reset=1 SHALL asynchronously force state=IDLE, pc=0, timeout counter=0; all outputs 0 (mem_addr=0).
REQ-030 reset asserted mid-operation SHALL discard in-flight fetch; no load pulse after reset assertion.

Configuration
REQ-031 Macro FETCH_SEQ_TIMEOUT_EN defined: counter of consecutive FETCH_HI/FETCH_LO cycles with mem_ready=0; reaching 16 -> FAULT (halted=1, mem_rd=0, exit only by reset); counter clears on every mem_ready or state change.
REQ-032 Macro undefined: no counter, no FAULT state; fetch waits indefinitely.

Structure
REQ-033 Shared package fetch_pkg SHALL hold the state enum typedef, default HALT_OP and TIMEOUT_CYCLES=16.
REQ-034 Sub-module wait_timer (the timeout counter) SHALL be instantiated only under FETCH_SEQ_TIMEOUT_EN; FSM otherwise flat.

Verification
REQ-035 Reset, mem_ready=1, run=1, opcode=8'h01, exec_done 1 cycle after exec_start -> load_upper at pc=0, load_lower at pc=1, exec_start next, pc=2 after.
REQ-036 mem_ready held 0 for 5 cycles in FETCH_HI -> mem_rd/mem_addr stable, no load pulse, pc unchanged; then proceeds.
REQ-037 opcode=8'hFF at DECODE -> no exec_start, halted=1, mem_rd stays 0 for 20 cycles.
REQ-038 exec_done with jump_en=1, jump_addr=8'h40 -> next mem_addr=8'h40; pc=8'hFF fetch -> next address 8'h00.
REQ-039 reset pulsed during FETCH_LO -> outputs 0 immediately, pc=0, restart from IDLE.
REQ-040 With FETCH_SEQ_TIMEOUT_EN, mem_ready=0 for 16 cycles -> halted=1; 15 cycles then ready -> normal fetch.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Desc     : Shared types and constants for the fetch sequencer. The FAULT
//            state exists only when FETCH_SEQ_TIMEOUT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam logic [7:0] DEFAULT_HALT_OP = 8'hFF;
    localparam int         TIMEOUT_CYCLES  = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_HI = 3'd1,
        ST_FETCH_LO = 3'd2,
        ST_DECODE   = 3'd3,
        ST_EXEC     = 3'd4,
        ST_HALT     = 3'd5
`ifdef FETCH_SEQ_TIMEOUT_EN
        ,
        ST_FAULT    = 3'd6
`endif
    } state_t;

endpackage

`default_nettype wire

// File: rtl/wait_timer.sv
// ============================================================================
// Module   : wait_timer
// Desc     : Counts consecutive stalled cycles; o_expired flags the cycle that
//            would make LIMIT stalls in a row.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_stall,
    output logic o_expired
);

    localparam int c_CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [c_CNT_W-1:0] r_count;

    // Any non-stall cycle restarts the count, so it only ever spans one wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!i_stall) begin
            r_count <= '0;
        end else if (!o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_stall && (r_count == c_CNT_W'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/fetch_seq.sv
// ============================================================================
// Module   : fetch_seq
// Desc     : Two-byte instruction fetch / decode / execute sequencer.
//            Define FETCH_SEQ_TIMEOUT_EN to add the stalled-fetch FAULT state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_seq
    import fetch_pkg::*;
#(
    parameter int         PC_W    = 8,
    parameter logic [7:0] HALT_OP = DEFAULT_HALT_OP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            mem_rd,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ready,
    output logic            load_upper,
    output logic            load_lower,
    input  logic [7:0]      opcode,
    output logic            exec_start,
    input  logic            exec_done,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_addr,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_mem_rd;
    logic            r_halted;

`ifdef FETCH_SEQ_TIMEOUT_EN
    logic w_stall;
    logic w_timeout;

    assign w_stall = ((r_state == ST_FETCH_HI) || (r_state == ST_FETCH_LO)) && !mem_ready;

    wait_timer #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_stall   (w_stall),
        .o_expired (w_timeout)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_mem_rd <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state  <= ST_FETCH_HI;
                        r_mem_rd <= 1'b1;
                    end
                end
                ST_FETCH_HI: begin
                    if (mem_ready) begin
                        r_pc    <= r_pc + 1'b1;
                        r_state <= ST_FETCH_LO;
                    end
`ifdef FETCH_SEQ_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state  <= ST_FAULT;
                        r_mem_rd <= 1'b0;
                        r_halted <= 1'b1;
                    end
`endif
                end
                ST_FETCH_LO: begin
                    if (mem_ready) begin
                        r_pc     <= r_pc + 1'b1;
                        r_state  <= ST_DECODE;
                        r_mem_rd <= 1'b0;
                    end
`ifdef FETCH_SEQ_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state  <= ST_FAULT;
                        r_mem_rd <= 1'b0;
                        r_halted <= 1'b1;
                    end
`endif
                end
                ST_DECODE: begin
                    if (opcode == HALT_OP) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // run is only consulted here, so a fetch in flight always completes.
                    if (exec_done) begin
                        if (jump_en) begin
                            r_pc <= jump_addr;
                        end
                        if (run) begin
                            r_state  <= ST_FETCH_HI;
                            r_mem_rd <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
`ifdef FETCH_SEQ_TIMEOUT_EN
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
`endif
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_rd <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd     = r_mem_rd;
    assign mem_addr   = r_pc;
    assign pc         = r_pc;
    assign halted     = r_halted;
    assign load_upper = (r_state == ST_FETCH_HI) && mem_ready;
    assign load_lower = (r_state == ST_FETCH_LO) && mem_ready;
    assign exec_start = (r_state == ST_DECODE) && (opcode != HALT_OP);

endmodule

`default_nettype wire
